// File: rtl/bus_pkg.sv
// Shared bus definitions: default packet geometry, packet layout and broadcast ID.
package bus_pkg;

   localparam int DEF_TAMA_PAQUETE = 32;
   localparam int DEF_PROFUNDIDAD  = 8;

   typedef struct packed {
      logic [7:0]                  dest;
      logic [DEF_TAMA_PAQUETE-9:0] payload;
   } paquete_t;

   localparam logic [7:0] BROADCAST_ID = 8'hFF;

endpackage

// File: rtl/fifo_ptr.sv
// Wrapping FIFO pointer: advances on inc, wraps profundidad-1 -> 0, async reset to 0.
module fifo_ptr
   import bus_pkg::*;
#(
   parameter int profundidad = DEF_PROFUNDIDAD
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           inc,
   output logic [$clog2(profundidad)-1:0] ptr
);

   localparam int PW = $clog2(profundidad);
   localparam logic [PW-1:0] LAST = PW'(profundidad - 1);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ptr <= '0;
      end else if (inc) begin
         ptr <= (ptr == LAST) ? '0 : ptr + PW'(1);
      end
   end

endmodule

// File: rtl/fifo_dispositivo.sv
// Per-device first-word fall-through FIFO between a device driver and the bus arbiter.
// Optional drop counter output overflow_cnt is built when FIFO_OVFL_CNT_EN is defined.
module fifo_dispositivo
   import bus_pkg::*;
#(
   parameter int tama_de_paquete = DEF_TAMA_PAQUETE,
   parameter int profundidad     = DEF_PROFUNDIDAD
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               push,
   input  logic [tama_de_paquete-1:0]         D_push,
   input  logic                               pop,
   output logic [tama_de_paquete-1:0]         D_pop,
   output logic                               pndng,
   output logic                               full,
   output logic [$clog2(profundidad+1)-1:0]   count
`ifdef FIFO_OVFL_CNT_EN
   ,
   output logic [15:0]                        overflow_cnt
`endif
);

   localparam int PW = $clog2(profundidad);
   localparam int CW = $clog2(profundidad + 1);

   logic [tama_de_paquete-1:0] mem [profundidad];
   logic [PW-1:0]              wr_ptr;
   logic [PW-1:0]              rd_ptr;
   logic                       do_push;
   logic                       do_pop;

   assign pndng = (count != '0);
   assign full  = (count == CW'(profundidad));

   // When full, a simultaneous pop frees the slot the write lands in, so the push is kept.
   assign do_pop  = pop & pndng;
   assign do_push = push & (~full | pop);

   fifo_ptr #(.profundidad(profundidad)) u_wr_ptr (
      .clk   (clk),
      .reset (reset),
      .inc   (do_push),
      .ptr   (wr_ptr)
   );

   fifo_ptr #(.profundidad(profundidad)) u_rd_ptr (
      .clk   (clk),
      .reset (reset),
      .inc   (do_pop),
      .ptr   (rd_ptr)
   );

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= D_push;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else begin
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   assign D_pop = pndng ? mem[rd_ptr] : '0;

`ifdef FIFO_OVFL_CNT_EN
   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         overflow_cnt <= '0;
      end else if (push & full & ~pop) begin
         overflow_cnt <= sat_inc16(overflow_cnt);
      end
   end
`endif

endmodule

// File: tb/tb_fifo_dispositivo.sv
// Directed self-checking bench for fifo_dispositivo (depth 8, 32-bit packets).
module tb_fifo_dispositivo;

   logic        clk;
   logic        reset;
   logic        push;
   logic [31:0] D_push;
   logic        pop;
   logic [31:0] D_pop;
   logic        pndng;
   logic        full;
   logic [3:0]  count;
`ifdef FIFO_OVFL_CNT_EN
   logic [15:0] overflow_cnt;
`endif

   int errors = 0;
   int checks = 0;

   fifo_dispositivo #(.tama_de_paquete(32), .profundidad(8)) dut (
      .clk    (clk),
      .reset  (reset),
      .push   (push),
      .D_push (D_push),
      .pop    (pop),
      .D_pop  (D_pop),
      .pndng  (pndng),
      .full   (full),
      .count  (count)
`ifdef FIFO_OVFL_CNT_EN
      ,
      .overflow_cnt (overflow_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset  = 1'b1;
      push   = 1'b0;
      pop    = 1'b0;
      D_push = '0;

      // 1. reset state and pop on empty
      #12;
      chk("rst_pndng", 32'(pndng), 32'd0);
      chk("rst_full",  32'(full),  32'd0);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_dpop",  D_pop,      32'd0);
`ifdef FIFO_OVFL_CNT_EN
      chk("rst_ovfl",  32'(overflow_cnt), 32'd0);
`endif
      @(negedge clk);
      reset = 1'b0;
      step();
      pop = 1'b1;
      step();
      pop = 1'b0;
      chk("empty_pop_count", 32'(count), 32'd0);
      chk("empty_pop_pndng", 32'(pndng), 32'd0);

      // 2. single push then pop
      push = 1'b1; D_push = 32'hA500_0001;
      chk("no_bypass_pndng", 32'(pndng), 32'd0);
      step();
      push = 1'b0;
      chk("one_pndng", 32'(pndng), 32'd1);
      chk("one_dpop",  D_pop,      32'hA500_0001);
      chk("one_count", 32'(count), 32'd1);
      pop = 1'b1;
      step();
      pop = 1'b0;
      chk("one_pop_pndng", 32'(pndng), 32'd0);
      chk("one_pop_dpop",  D_pop,      32'd0);

      // 3. fill, overflow drop, drain in order
      for (int i = 0; i < 8; i++) begin
         push = 1'b1; D_push = 32'(i);
         step();
      end
      push = 1'b0;
      chk("fill_full",  32'(full),  32'd1);
      chk("fill_count", 32'(count), 32'd8);
      push = 1'b1; D_push = 32'h0000_DEAD;
      step();
      push = 1'b0;
      chk("drop_count", 32'(count), 32'd8);
      chk("drop_head",  D_pop,      32'd0);
`ifdef FIFO_OVFL_CNT_EN
      chk("drop_ovfl",  32'(overflow_cnt), 32'd1);
`endif
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("drain_%0d", i), D_pop, 32'(i));
         pop = 1'b1;
         step();
      end
      pop = 1'b0;
      chk("drain_count", 32'(count), 32'd0);
      chk("drain_dpop",  D_pop,      32'd0);

      // 4. steady push/pop with count 3 across pointer wrap
      for (int i = 0; i < 3; i++) begin
         push = 1'b1; D_push = 32'h100 + 32'(i);
         step();
      end
      for (int k = 0; k < 20; k++) begin
         push = 1'b1; pop = 1'b1; D_push = 32'h103 + 32'(k);
         chk($sformatf("wrap_data_%0d", k), D_pop, 32'h100 + 32'(k));
         step();
         chk($sformatf("wrap_count_%0d", k), 32'(count), 32'd3);
      end
      push = 1'b0;
      for (int i = 0; i < 3; i++) begin
         pop = 1'b1;
         chk($sformatf("wrap_tail_%0d", i), D_pop, 32'h114 + 32'(i));
         step();
      end
      pop = 1'b0;
      chk("wrap_empty", 32'(count), 32'd0);

      // 5a. push and pop while empty
      push = 1'b1; pop = 1'b1; D_push = 32'h55;
      step();
      push = 1'b0; pop = 1'b0;
      chk("emp_pp_count", 32'(count), 32'd1);
      chk("emp_pp_dpop",  D_pop,      32'h55);
      pop = 1'b1;
      step();
      pop = 1'b0;

      // 5b. push and pop while full
      for (int i = 0; i < 8; i++) begin
         push = 1'b1; D_push = 32'h200 + 32'(i);
         step();
      end
      push = 1'b1; pop = 1'b1; D_push = 32'h77;
      chk("full_pp_head", D_pop, 32'h200);
      step();
      push = 1'b0; pop = 1'b0;
      chk("full_pp_count", 32'(count), 32'd8);
      chk("full_pp_full",  32'(full),  32'd1);
`ifdef FIFO_OVFL_CNT_EN
      chk("full_pp_ovfl",  32'(overflow_cnt), 32'd1);
`endif
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("full_pp_out_%0d", i), D_pop, (i == 7) ? 32'h77 : 32'h201 + 32'(i));
         pop = 1'b1;
         step();
      end
      pop = 1'b0;
      chk("full_pp_empty", 32'(count), 32'd0);

      // 6. reset between edges with count 5
      for (int i = 0; i < 5; i++) begin
         push = 1'b1; D_push = 32'h300 + 32'(i);
         step();
      end
      chk("pre_rst_count", 32'(count), 32'd5);
      push = 1'b1; pop = 1'b1; D_push = 32'h999;
      reset = 1'b1;
      #1;
      chk("mid_rst_count", 32'(count), 32'd0);
      chk("mid_rst_pndng", 32'(pndng), 32'd0);
      chk("mid_rst_dpop",  D_pop,      32'd0);
      step();
      push = 1'b0; pop = 1'b0;
      chk("held_rst_count", 32'(count), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      push = 1'b1; D_push = 32'h0000_ABCD;
      step();
      push = 1'b0;
      chk("post_rst_dpop",  D_pop,      32'h0000_ABCD);
      chk("post_rst_count", 32'(count), 32'd1);
`ifdef FIFO_OVFL_CNT_EN
      chk("post_rst_ovfl",  32'(overflow_cnt), 32'd0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
